fifo_write_arbiter: RTL and testbench

//  Shares one write port of the sender-side fifo (WE/DATA_W/FULL/SOFT_RST) between NUM_REQ producers.

---
 rtl/fifo_write_arbiter_pkg.sv | 24 ++
 rtl/fifo_arb_rr_pick.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// STALL_CNT_W sizes the optional stall counter (FIFO_WRITE_ARB_STALL_EN).
package fifo_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        logic [STALL_CNT_W-1:0] r;
        if (v == {STALL_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STALL_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: first set bit of valid when searching from rr_ptr upward, wrapping.
// Rotates the request vector so rr_ptr lands at bit 0, then priority-encodes.
module fifo_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [NUM_REQ-1:0] rot_s;

    // Rotate requests so that position k means requester (rr_ptr + k) mod NUM_REQ.
    always_comb begin
        rot_s = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_s[k] = valid[(int'(rr_ptr) + k) % NUM_REQ];
        end
    end

    // Lowest rotated position wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        found = |valid;
        index = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            index = rot_s[k] ? IDX_W'((int'(rr_ptr) + k) % NUM_REQ) : index;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port, plus FIFO flush sequencing.
// Optional stall counter enabled by defining FIFO_WRITE_ARB_STALL_EN.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_DATA,
    input  logic [NUM_REQ-1:0]         REQ_LAST,
    output logic [NUM_REQ-1:0]         REQ_READY,
    output logic [WIDTH-1:0]           FIFO_DATA_W,
    output logic                       FIFO_WE,
    input  logic                       FIFO_FULL,
    output logic                       FIFO_SOFT_RST,
    input  logic                       FLUSH_REQ,
    output logic                       FLUSH_DONE,
    output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
    output logic                       BUSY,
    output logic [STALL_CNT_W-1:0]     STALL_CNT
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_r, state_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0] grant_r, grant_nxt_s;
    logic [CNT_W-1:0] beat_r, beat_nxt_s;
    logic             pick_found_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             grant_ready_s;
    logic             xfer_s;
    logic             burst_end_s;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid  (REQ_VALID),
        .rr_ptr (rr_ptr_r),
        .found  (pick_found_s),
        .index  (pick_idx_s)
    );

    // A flush request blocks the handshake in the same cycle so the abandoned burst writes nothing more.
    assign grant_ready_s = (state_r == ARB_BURST) & ~FIFO_FULL & ~FLUSH_REQ;
    assign xfer_s        = grant_ready_s & REQ_VALID[grant_r];
    assign burst_end_s   = REQ_LAST[grant_r] | (beat_r == LAST_BEAT);

    assign FIFO_WE       = xfer_s;
    assign FIFO_DATA_W   = REQ_DATA[int'(grant_r)*WIDTH +: WIDTH];
    assign FIFO_SOFT_RST = (state_r == ARB_FLUSH);
    assign FLUSH_DONE    = (state_r == ARB_FLUSH);
    assign BUSY          = (state_r != ARB_IDLE);
    assign GRANT_ID      = grant_r;

    // Only the current grantee ever sees READY.
    always_comb begin
        REQ_READY          = {NUM_REQ{1'b0}};
        REQ_READY[grant_r] = grant_ready_s;
    end

    // Next-state, grant, round-robin pointer and beat counter.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        grant_nxt_s  = grant_r;
        beat_nxt_s   = beat_r;
        case (state_r)
            ARB_IDLE: begin
                if (FLUSH_REQ) begin
                    state_nxt_s = ARB_FLUSH;
                end else if (pick_found_s) begin
                    grant_nxt_s = pick_idx_s;
                    beat_nxt_s  = {CNT_W{1'b0}};
                    state_nxt_s = ARB_BURST;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                if (FLUSH_REQ) begin
                    state_nxt_s = ARB_FLUSH;
                end else if (xfer_s && burst_end_s) begin
                    beat_nxt_s   = {CNT_W{1'b0}};
                    rr_ptr_nxt_s = (grant_r == LAST_IDX) ? {IDX_W{1'b0}} : grant_r + IDX_W'(1);
                    state_nxt_s  = ARB_IDLE;
                end else if (xfer_s) begin
                    beat_nxt_s = beat_r + CNT_W'(1);
                end else begin
                    state_nxt_s = ARB_BURST;
                end
            end
            ARB_FLUSH: begin
                rr_ptr_nxt_s = {IDX_W{1'b0}};
                beat_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s  = ARB_IDLE;
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ARB_IDLE;
            rr_ptr_r <= {IDX_W{1'b0}};
            grant_r  <= {IDX_W{1'b0}};
            beat_r   <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            beat_r   <= beat_nxt_s;
        end
    end

`ifdef FIFO_WRITE_ARB_STALL_EN
    logic [STALL_CNT_W-1:0] stall_r;

    // Counts cycles the grantee has a word ready but the FIFO is full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_r <= {STALL_CNT_W{1'b0}};
        end else if (state_r == ARB_FLUSH) begin
            stall_r <= {STALL_CNT_W{1'b0}};
        end else if ((state_r == ARB_BURST) && REQ_VALID[grant_r] && FIFO_FULL) begin
            stall_r <= sat_inc(stall_r);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign STALL_CNT = stall_r;
`else
    assign STALL_CNT = {STALL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (WIDTH=8, NUM_REQ=4, MAX_BURST=4).
// Directed scenarios plus a randomized run checked against a behavioural model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int WIDTH     = 8;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
`ifdef FIFO_WRITE_ARB_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_data_w;
    logic        fifo_we;
    logic        fifo_full;
    logic        fifo_soft_rst;
    logic        flush_req;
    logic        flush_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    int         seq [4];
    int         burst_len [4];
    logic [3:0] last_acc;
    logic [7:0] wlog [$];

    // behavioural model of the arbiter
    bit m_burst, m_flush;
    int m_g, m_beats, m_ptr, m_stall;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_LAST(req_last),
        .REQ_READY(req_ready), .FIFO_DATA_W(fifo_data_w), .FIFO_WE(fifo_we), .FIFO_FULL(fifo_full),
        .FIFO_SOFT_RST(fifo_soft_rst), .FLUSH_REQ(flush_req), .FLUSH_DONE(flush_done),
        .GRANT_ID(grant_id), .BUSY(busy), .STALL_CNT(stall_cnt)
    );

    function automatic logic [7:0] word(input int i, input int s);
        logic [7:0] w;
        w = {i[1:0], s[5:0]};
        return w;
    endfunction

    task automatic refresh_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*8 +: 8] = word(i, seq[i]);
            req_last[i] = (burst_len[i] != 0) && ((seq[i] % burst_len[i]) == burst_len[i] - 1);
        end
    endtask

    task automatic tick();
        logic       we_s;
        logic [7:0] d_s;
        #1;
        last_acc = req_valid & req_ready;
        we_s = fifo_we;
        d_s  = fifo_data_w;
        @(posedge clk);
        #1;
        if (we_s) wlog.push_back(d_s);
        for (int i = 0; i < NUM_REQ; i++) if (last_acc[i]) seq[i]++;
        refresh_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        flush_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i] = 0;
            burst_len[i] = 0;
        end
        refresh_inputs();
        tick();
        tick();
        rst = 1'b0;
        wlog.delete();
        m_burst = 1'b0; m_flush = 1'b0; m_g = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        req_valid = 4'b0001;
        tick(); tick(); tick();
        fifo_full = 1'b1;
        tick(); tick();
        checks++;
        if (stall_cnt !== (STALL_ON ? 16'd2 : 16'd0))
            begin errors++; $display("FAIL pre_reset_stall got=%0d exp=%0d", stall_cnt, STALL_ON ? 2 : 0); end
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        #1;
        checks++;
        if ({req_ready, fifo_we, fifo_soft_rst, flush_done, busy, grant_id} !== 10'b0)
            begin errors++; $display("FAIL reset_outputs got rdy=%b we=%b srst=%b done=%b busy=%b gid=%0d",
                req_ready, fifo_we, fifo_soft_rst, flush_done, busy, grant_id); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        rst = 1'b0;
        fifo_full = 1'b0;
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic       exp_we;
        logic [1:0] exp_g;
        logic [7:0] exp_w;
        apply_reset();
        req_valid = 4'b0101;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_we = !(c == 0 || c == 5 || c == 10);
            checks++;
            if (fifo_we !== exp_we) begin errors++; $display("FAIL rr_we c=%0d got=%b exp=%b", c, fifo_we, exp_we); end
            if (c == 1 || c == 6 || c == 11) begin
                exp_g = (c == 6) ? 2'd2 : 2'd0;
                checks++;
                if (grant_id !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d got=%0d exp=%0d", c, grant_id, exp_g); end
            end
            tick();
        end
        checks++;
        if (wlog.size() != 12) begin errors++; $display("FAIL rr_count got=%0d exp=12", wlog.size()); end
        for (int k = 0; k < 12 && k < wlog.size(); k++) begin
            exp_w = word((k >= 4 && k < 8) ? 2 : 0, (k < 4) ? k : k - 4);
            checks++;
            if (wlog[k] !== exp_w) begin errors++; $display("FAIL rr_word k=%0d got=%h exp=%h", k, wlog[k], exp_w); end
        end
    endtask

    task automatic test_last();
        apply_reset();
        burst_len[1] = 2;
        refresh_inputs();
        req_valid = 4'b0010;
        tick();
        #1;
        checks++;
        if (fifo_we !== 1'b1 || req_ready !== 4'b0010)
            begin errors++; $display("FAIL last_w0 got we=%b rdy=%b exp we=1 rdy=0010", fifo_we, req_ready); end
        tick();
        #1;
        checks++;
        if (fifo_we !== 1'b1 || fifo_data_w !== word(1, 1))
            begin errors++; $display("FAIL last_w1 got we=%b data=%h exp we=1 data=%h", fifo_we, fifo_data_w, word(1, 1)); end
        tick();
        req_valid = 4'b1111;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_we !== 1'b0)
            begin errors++; $display("FAIL last_idle got busy=%b we=%b exp 0 0", busy, fifo_we); end
        tick();
        #1;
        checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1)
            begin errors++; $display("FAIL last_next_grant got gid=%0d busy=%b exp gid=2 busy=1", grant_id, busy); end
        checks++;
        if (wlog.size() != 2) begin errors++; $display("FAIL last_count got=%0d exp=2", wlog.size()); end
    endtask

    task automatic test_full_stall();
        logic exp_we;
        apply_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            #1;
            exp_we = (c != 0) && (c != 8) && !fifo_full;
            checks++;
            if (fifo_we !== exp_we) begin errors++; $display("FAIL full_we c=%0d got=%b exp=%b", c, fifo_we, exp_we); end
            if (fifo_full) begin
                checks++;
                if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_ready c=%0d got=%b exp=0000", c, req_ready); end
            end
            tick();
        end
        fifo_full = 1'b0;
        checks++;
        if (wlog.size() != 4) begin errors++; $display("FAIL full_count got=%0d exp=4", wlog.size()); end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            checks++;
            if (wlog[k] !== word(0, k)) begin errors++; $display("FAIL full_word k=%0d got=%h exp=%h", k, wlog[k], word(0, k)); end
        end
        checks++;
        if (stall_cnt !== (STALL_ON ? 16'd3 : 16'd0))
            begin errors++; $display("FAIL full_stall got=%0d exp=%0d", stall_cnt, STALL_ON ? 3 : 0); end
    endtask

    task automatic test_flush();
        apply_reset();
        req_valid = 4'b1000;
        tick();
        #1;
        checks++;
        if (fifo_we !== 1'b1 || grant_id !== 2'd3)
            begin errors++; $display("FAIL flush_w0 got we=%b gid=%0d exp we=1 gid=3", fifo_we, grant_id); end
        tick();
        flush_req = 1'b1;
        #1;
        checks++;
        if (fifo_we !== 1'b0 || req_ready !== 4'b0000)
            begin errors++; $display("FAIL flush_block got we=%b rdy=%b exp we=0 rdy=0000", fifo_we, req_ready); end
        tick();
        flush_req = 1'b0;
        req_valid = 4'b1001;
        #1;
        checks++;
        if (fifo_soft_rst !== 1'b1 || flush_done !== 1'b1)
            begin errors++; $display("FAIL flush_pulse got srst=%b done=%b exp 1 1", fifo_soft_rst, flush_done); end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_soft_rst !== 1'b0 || flush_done !== 1'b0)
            begin errors++; $display("FAIL flush_idle got busy=%b srst=%b done=%b exp 0 0 0", busy, fifo_soft_rst, flush_done); end
        tick();
        #1;
        checks++;
        if (grant_id !== 2'd0 || fifo_we !== 1'b1 || fifo_data_w !== word(0, 0))
            begin errors++; $display("FAIL flush_regrant got gid=%0d we=%b data=%h exp gid=0 we=1 data=%h",
                grant_id, fifo_we, fifo_data_w, word(0, 0)); end
        tick();
        checks++;
        if (wlog.size() != 2) begin errors++; $display("FAIL flush_count got=%0d exp=2", wlog.size()); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req_valid = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if ({req_ready, fifo_we, busy, grant_id, fifo_soft_rst} !== 9'b0)
            begin errors++; $display("FAIL midrst_outputs got rdy=%b we=%b busy=%b gid=%0d srst=%b",
                req_ready, fifo_we, busy, grant_id, fifo_soft_rst); end
        rst = 1'b0;
        req_valid = 4'b0101;
        tick();
        #1;
        checks++;
        if (grant_id !== 2'd0 || fifo_we !== 1'b1)
            begin errors++; $display("FAIL midrst_regrant got gid=%0d we=%b exp gid=0 we=1", grant_id, fifo_we); end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) tick();
        req_valid = 4'b0010;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle got busy=%b exp=0", busy); end
        tick();
        #1;
        checks++;
        if (grant_id !== 2'd1 || req_ready !== 4'b0010)
            begin errors++; $display("FAIL wrap_grant got gid=%0d rdy=%b exp gid=1 rdy=0010", grant_id, req_ready); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  exp_rdy;
        logic        exp_we;
        logic [15:0] exp_stall;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) burst_len[i] = $urandom_range(0, 5);
        refresh_inputs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] || last_acc[i]) req_valid[i] = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            flush_req = ($urandom_range(0, 15) == 0);
            #1;
            exp_rdy = (m_burst && !fifo_full && !flush_req) ? (4'b0001 << m_g) : 4'b0000;
            exp_we  = exp_rdy[m_g] & req_valid[m_g];
            exp_stall = STALL_ON ? 16'(m_stall) : 16'd0;
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            checks++;
            if (fifo_we !== exp_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, fifo_we, exp_we); end
            if (exp_we) begin
                checks++;
                if (fifo_data_w !== word(m_g, seq[m_g]))
                    begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, fifo_data_w, word(m_g, seq[m_g])); end
            end
            checks++;
            if (busy !== (m_burst || m_flush) || fifo_soft_rst !== m_flush || flush_done !== m_flush)
                begin errors++; $display("FAIL rnd_status cyc=%0d got busy=%b srst=%b done=%b exp busy=%b flush=%b",
                    cyc, busy, fifo_soft_rst, flush_done, m_burst || m_flush, m_flush); end
            checks++;
            if (grant_id !== 2'(m_g)) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_g); end
            checks++;
            if (stall_cnt !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp_stall); end
            // advance the model by one clock using the inputs seen this cycle
            if (m_flush) begin
                m_flush = 1'b0; m_ptr = 0; m_stall = 0;
            end else if (m_burst) begin
                if (req_valid[m_g] && fifo_full && m_stall < 65535) m_stall++;
                if (flush_req) begin
                    m_burst = 1'b0; m_flush = 1'b1;
                end else if (exp_we) begin
                    m_beats++;
                    if (req_last[m_g] || m_beats == MAX_BURST) begin
                        m_burst = 1'b0; m_ptr = (m_g + 1) % NUM_REQ;
                    end
                end
            end else if (flush_req) begin
                m_flush = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++)
                    if (!m_burst && req_valid[(m_ptr + k) % NUM_REQ]) begin
                        m_g = (m_ptr + k) % NUM_REQ; m_beats = 0; m_burst = 1'b1;
                    end
            end
            tick();
        end
        flush_req = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = 32'd0;
        req_last = 4'b0000;
        fifo_full = 1'b0;
        flush_req = 1'b0;
        last_acc = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_last();
        test_full_stall();
        test_flush();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
